// File: rtl/alu_wb_stage.sv
// alu_wb_stage: retire/writeback stage behind the DSP48E1 execution unit.
// It follows every issued op through the fixed DSP latency. It samples P in
// the op's retire cycle and drives the register-file write port and flags.
// An op whose retire cycle collides with an in-flight op is held off issue.
// Optional feature macro: ALU_WB_FWD_EN adds a combinational bypass port
// (fwd_*) that shows the retiring result one cycle before wb_*.
module alu_wb_stage #(
    parameter int LAT_ALU      = 3,
    parameter int LAT_MUL      = 4,
    parameter int DATA_W       = 32,
    parameter int RD_W         = 5,
    parameter bit R0_HARDWIRED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid_i,
    input  logic              issue_usemult_i,
    input  logic              issue_wen_i,
    input  logic [RD_W-1:0]   issue_rd_i,
    output logic              issue_ready_o,
    input  logic              flush_i,
    input  logic [47:0]       p_i,
    output logic              wb_we_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              wb_zero_o,
    output logic              wb_neg_o,
    output logic              wb_carry_o,
`ifdef ALU_WB_FWD_EN
    output logic              fwd_valid_o,
    output logic [RD_W-1:0]   fwd_rd_o,
    output logic [DATA_W-1:0] fwd_data_o,
`endif
    output logic              inflight_o
);

    // A retiring op writes only if it asked to write and does not target a
    // hardwired-zero r0.
    function automatic logic rd_writes(input logic wen, input logic [RD_W-1:0] rd);
        return wen & ~(R0_HARDWIRED & (rd == {RD_W{1'b0}}));
    endfunction

    // Retire slots: index k means "retires k cycles from now".
    logic [LAT_MUL:1]           busy_q, busy_d;
    logic [LAT_MUL:1]           wen_q,  wen_d;
    logic [LAT_MUL:1][RD_W-1:0] rd_q,   rd_d;
    logic                       inflight_q;
    logic                       issue_acc_s;

    logic              wb_we_q;
    logic [RD_W-1:0]   wb_rd_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              wb_zero_q;
    logic              wb_neg_q;
    logic              wb_carry_q;

    // The upper P bits are not architectural. They are deliberately dropped.
    logic              unused_p_s;
    assign unused_p_s = ^p_i[47:DATA_W+1];

    // After the shift, slot L must be free. Slot L holds what slot L+1 holds
    // now. A mult uses the deepest slot, so it never stalls.
    assign issue_ready_o = issue_usemult_i ? 1'b1 : ~busy_q[LAT_ALU+1];
    assign issue_acc_s   = issue_valid_i & issue_ready_o & ~flush_i;

    // Next slot state: shift toward retire, then insert the accepted op or flush.
    always_comb begin
        busy_d = {1'b0, busy_q[LAT_MUL:2]};
        wen_d  = {1'b0, wen_q[LAT_MUL:2]};
        rd_d   = {{RD_W{1'b0}}, rd_q[LAT_MUL:2]};
        if (flush_i) begin
            busy_d = {LAT_MUL{1'b0}};
        end else if (issue_acc_s) begin
            if (issue_usemult_i) begin
                busy_d[LAT_MUL] = 1'b1;
                wen_d[LAT_MUL]  = issue_wen_i;
                rd_d[LAT_MUL]   = issue_rd_i;
            end else begin
                busy_d[LAT_ALU] = 1'b1;
                wen_d[LAT_ALU]  = issue_wen_i;
                rd_d[LAT_ALU]   = issue_rd_i;
            end
        end else begin
            busy_d = busy_d;
        end
    end

    // Slot pipeline registers and the busy summary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= {LAT_MUL{1'b0}};
            wen_q      <= {LAT_MUL{1'b0}};
            rd_q       <= {(LAT_MUL*RD_W){1'b0}};
            inflight_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            wen_q      <= wen_d;
            rd_q       <= rd_d;
            inflight_q <= |busy_d;
        end
    end

    // Writeback registers. They sample slot 1 and P when an op retires.
    // Otherwise they hold, and only the write enable drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we_q    <= 1'b0;
            wb_rd_q    <= {RD_W{1'b0}};
            wb_data_q  <= {DATA_W{1'b0}};
            wb_zero_q  <= 1'b0;
            wb_neg_q   <= 1'b0;
            wb_carry_q <= 1'b0;
        end else if (busy_q[1]) begin
            wb_we_q    <= rd_writes(wen_q[1], rd_q[1]);
            wb_rd_q    <= rd_q[1];
            wb_data_q  <= p_i[DATA_W-1:0];
            wb_zero_q  <= (p_i[DATA_W-1:0] == {DATA_W{1'b0}});
            wb_neg_q   <= p_i[DATA_W-1];
            wb_carry_q <= p_i[DATA_W];
        end else begin
            wb_we_q    <= 1'b0;
        end
    end

    assign wb_we_o    = wb_we_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign wb_zero_o  = wb_zero_q;
    assign wb_neg_o   = wb_neg_q;
    assign wb_carry_o = wb_carry_q;
    assign inflight_o = inflight_q;

`ifdef ALU_WB_FWD_EN
    // Bypass: this is the result being written at the coming edge.
    assign fwd_valid_o = busy_q[1] & rd_writes(wen_q[1], rd_q[1]);
    assign fwd_rd_o    = rd_q[1];
    assign fwd_data_o  = p_i[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Testbench for alu_wb_stage. The reference model is a schedule of retire
// events indexed by absolute cycle number.
module tb_alu_wb_stage;
    localparam int LAT_ALU = 3;
    localparam int LAT_MUL = 4;
    localparam int NCYC    = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid_i, issue_usemult_i, issue_wen_i, flush_i;
    logic [4:0]  issue_rd_i;
    logic        issue_ready_o;
    logic [47:0] p_i;
    logic        wb_we_o, wb_zero_o, wb_neg_o, wb_carry_o, inflight_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
`ifdef ALU_WB_FWD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
`endif

    always #5 clk = ~clk;

    alu_wb_stage dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid_i), .issue_usemult_i(issue_usemult_i),
        .issue_wen_i(issue_wen_i), .issue_rd_i(issue_rd_i),
        .issue_ready_o(issue_ready_o), .flush_i(flush_i), .p_i(p_i),
        .wb_we_o(wb_we_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .wb_zero_o(wb_zero_o), .wb_neg_o(wb_neg_o), .wb_carry_o(wb_carry_o),
`ifdef ALU_WB_FWD_EN
        .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
`endif
        .inflight_o(inflight_o)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    // Model: sv[c] = an op retires at the edge ending cycle c.
    bit         sv [NCYC];
    bit         sw [NCYC];
    logic [4:0] sr [NCYC];
    int         cyc = 0;
    bit         last_ready;
    logic        exp_we, exp_zero, exp_neg, exp_carry, exp_inflight;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NCYC; i++) sv[i] = 1'b0;
        exp_we = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
        exp_zero = 1'b0; exp_neg = 1'b0; exp_carry = 1'b0; exp_inflight = 1'b0;
    endtask

    // This task is called at posedge+1. It checks the outputs of the last edge,
    // drives one cycle, advances the model, and returns at the next posedge+1.
    task automatic step(input bit v, input bit um, input bit wen, input logic [4:0] rd,
                        input bit fl, input logic [47:0] p);
        int lat;
        bit rdy_exp, acc, act;
        chk("wb_we", 64'(wb_we_o), 64'(exp_we));
        chk("wb_rd", 64'(wb_rd_o), 64'(exp_rd));
        chk("wb_data", 64'(wb_data_o), 64'(exp_data));
        chk("wb_zero", 64'(wb_zero_o), 64'(exp_zero));
        chk("wb_neg", 64'(wb_neg_o), 64'(exp_neg));
        chk("wb_carry", 64'(wb_carry_o), 64'(exp_carry));
        chk("inflight", 64'(inflight_o), 64'(exp_inflight));
        issue_valid_i = v; issue_usemult_i = um; issue_wen_i = wen;
        issue_rd_i = rd; flush_i = fl; p_i = p;
        #1;
        lat = um ? LAT_MUL : LAT_ALU;
        rdy_exp = !sv[cyc + lat];
        last_ready = issue_ready_o;
        chk("issue_ready", 64'(issue_ready_o), 64'(rdy_exp));
        acc = v && rdy_exp && !fl;
        act = sv[cyc] && sw[cyc] && (sr[cyc] != 5'd0);
`ifdef ALU_WB_FWD_EN
        chk("fwd_valid", 64'(fwd_valid_o), 64'(act));
        if (act) begin
            chk("fwd_rd", 64'(fwd_rd_o), 64'(sr[cyc]));
            chk("fwd_data", 64'(fwd_data_o), 64'(p[31:0]));
        end
`endif
        if (sv[cyc]) begin
            exp_we = act; exp_rd = sr[cyc]; exp_data = p[31:0];
            exp_zero = (p[31:0] == 32'd0); exp_neg = p[31]; exp_carry = p[32];
        end else begin
            exp_we = 1'b0;
        end
        sv[cyc] = 1'b0;
        if (fl) begin
            for (int k = 1; k <= LAT_MUL; k++) sv[cyc + k] = 1'b0;
        end else if (acc) begin
            sv[cyc + lat] = 1'b1; sw[cyc + lat] = wen; sr[cyc + lat] = rd;
        end
        exp_inflight = 1'b0;
        for (int k = 1; k <= LAT_MUL; k++) if (sv[cyc + k]) exp_inflight = 1'b1;
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic [47:0] p);
        step(1'b0, 1'b0, 1'b0, 5'd0, 1'b0, p);
    endtask

    initial begin
        logic [47:0] rp;
        rst_n = 1'b0; issue_valid_i = 1'b0; issue_usemult_i = 1'b0; issue_wen_i = 1'b0;
        issue_rd_i = 5'd0; flush_i = 1'b0; p_i = 48'd0;
        clear_model();
        #12;
        chk("rst_we", 64'(wb_we_o), 64'd0);
        chk("rst_data", 64'(wb_data_o), 64'd0);
        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        @(posedge clk); #1; rst_n = 1'b1;

        // Test 1: reset while three ops are in flight.
        step(1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 48'h1);
        step(1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 48'h2);
        step(1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 48'h3);
        issue_valid_i = 1'b1; issue_usemult_i = 1'b0;
        #2 rst_n = 1'b0; #1;
        chk("midrst_we", 64'(wb_we_o), 64'd0);
        chk("midrst_rd", 64'(wb_rd_o), 64'd0);
        chk("midrst_data", 64'(wb_data_o), 64'd0);
        chk("midrst_flags", 64'({wb_zero_o, wb_neg_o, wb_carry_o}), 64'd0);
        chk("midrst_inflight", 64'(inflight_o), 64'd0);
        chk("midrst_ready", 64'(issue_ready_o), 64'd1);
        @(posedge clk); #1; rst_n = 1'b1; cyc++;
        clear_model();
        step(1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 48'h0);
        idle(48'h0); idle(48'h0); idle(48'h5);
        chk("t1_we", 64'(wb_we_o), 64'd1);
        chk("t1_rd", 64'(wb_rd_o), 64'd7);
        chk("t1_data", 64'(wb_data_o), 64'd5);

        // Test 2: the ALU op's result is zero.
        step(1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 48'h1234);
        idle(48'h77); idle(48'h88); idle(48'h1_0000_0000);
        chk("t2_we", 64'(wb_we_o), 64'd1);
        chk("t2_rd", 64'(wb_rd_o), 64'd3);
        chk("t2_zero", 64'(wb_zero_o), 64'd1);
        chk("t2_neg", 64'(wb_neg_o), 64'd0);
        chk("t2_carry", 64'(wb_carry_o), 64'd1);

        // Test 3: an ALU op presented right after a mult stalls for one cycle.
        step(1'b1, 1'b1, 1'b1, 5'd10, 1'b0, 48'h0);
        step(1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 48'h0);
        chk("t3_stall", 64'(last_ready), 64'd0);
        step(1'b1, 1'b0, 1'b1, 5'd11, 1'b0, 48'h0);
        chk("t3_accept", 64'(last_ready), 64'd1);
        idle(48'h0); idle(48'h111);
        chk("t3_mul_rd", 64'(wb_rd_o), 64'd10);
        chk("t3_mul_data", 64'(wb_data_o), 64'h111);
        idle(48'h222);
        chk("t3_alu_rd", 64'(wb_rd_o), 64'd11);
        chk("t3_alu_we", 64'(wb_we_o), 64'd1);

        // Test 4: four back-to-back ALU ops.
        for (int n = 0; n < 8; n++) begin
            rp = (n >= 3 && n <= 6) ? 48'h8000_0000 + 48'(n - 2) : 48'h0;
            step(n < 4, 1'b0, 1'b1, 5'(n + 1), 1'b0, rp);
            if (n >= 3 && n <= 6) begin
                chk("t4_we", 64'(wb_we_o), 64'd1);
                chk("t4_rd", 64'(wb_rd_o), 64'(n - 2));
                chk("t4_neg", 64'(wb_neg_o), 64'd1);
            end
        end

        // Test 5: a flush kills in-flight ops. A write to r0 is suppressed.
        step(1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 48'h0);
        step(1'b1, 1'b0, 1'b1, 5'd6, 1'b1, 48'h0);
        chk("t5_inflight", 64'(inflight_o), 64'd0);
        for (int n = 0; n < 5; n++) begin
            idle(48'hABC);
            chk("t5_we", 64'(wb_we_o), 64'd0);
        end
        step(1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 48'h0);
        idle(48'h0); idle(48'h0); idle(48'h99);
        chk("t5_r0_we", 64'(wb_we_o), 64'd0);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 400; n++) begin
            rp = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) rp[31:0] = 32'd0;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0,
                 5'($urandom_range(0, 31)), $urandom_range(0, 15) == 0, rp);
        end
        for (int n = 0; n < 6; n++) idle(48'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
